// File: rtl/pipe_debug_monitor.sv
// Pipeline debug monitor: per-stage vld/rdy stats, address-match capture, 1-cycle registered readout.
// Pure observer, never backpressures; define DBG_STALL_CNT_EN to add per-stage stall counters.
module pipe_debug_monitor #(
    parameter int          N_STAGES  = 4,
    parameter int          N_CAPT    = 2,
    parameter int          CNT_W     = 32,
    parameter int          ADDR_W    = 16,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] SIGNATURE = 32'd13122003
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       freeze_i,
    input  logic [N_STAGES-1:0]        stage_vld_i,
    input  logic [N_STAGES-1:0]        stage_rdy_i,
    input  logic                       mon_en_i,
    input  logic [ADDR_W-1:0]          mon_addr_i,
    input  logic [DATA_W-1:0]          mon_data_i,
    input  logic [N_CAPT*ADDR_W-1:0]   capt_addr_i,
    input  logic [7:0]                 sel_i,
    output logic [31:0]                debug_o,
    output logic [2*N_STAGES-1:0]      flags_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    r_cyc_cnt;
    logic [N_STAGES-1:0] r_vld_seen;
    logic [N_STAGES-1:0] r_rdy_seen;
    logic [CNT_W-1:0]    r_vld_cnt   [N_STAGES];
    logic [CNT_W-1:0]    r_first_ts  [N_STAGES];
    logic [DATA_W-1:0]   r_capt_data [N_CAPT];
    logic [N_CAPT-1:0]   r_capt_hit;
    logic [N_CAPT-1:0]   w_match;
    logic [31:0]         w_rd;
    logic [31:0]         w_stall_rd;

    always_comb begin
        w_match = '0;
        for (int k = 0; k < N_CAPT; k++)
            w_match[k] = mon_en_i && (mon_addr_i == capt_addr_i[k*ADDR_W +: ADDR_W]);
    end

    // Reset and clear both zero the statistics, so they share one branch.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            r_cyc_cnt  <= '0;
            r_vld_seen <= '0;
            r_rdy_seen <= '0;
            r_capt_hit <= '0;
            for (int i = 0; i < N_STAGES; i++) begin
                r_vld_cnt[i]  <= '0;
                r_first_ts[i] <= '0;
            end
            for (int k = 0; k < N_CAPT; k++)
                r_capt_data[k] <= '0;
        end else if (!freeze_i) begin
            if (r_cyc_cnt != CNT_MAX)
                r_cyc_cnt <= r_cyc_cnt + 1'b1;
            for (int i = 0; i < N_STAGES; i++) begin
                if (stage_vld_i[i]) begin
                    if (r_vld_cnt[i] != CNT_MAX)
                        r_vld_cnt[i] <= r_vld_cnt[i] + 1'b1;
                    if (!r_vld_seen[i])
                        r_first_ts[i] <= r_cyc_cnt;
                end
            end
            r_vld_seen <= r_vld_seen | stage_vld_i;
            r_rdy_seen <= r_rdy_seen | stage_rdy_i;
            for (int k = 0; k < N_CAPT; k++) begin
                if (w_match[k]) begin
                    r_capt_data[k] <= mon_data_i;
                    r_capt_hit[k]  <= 1'b1;
                end
            end
        end
    end

`ifdef DBG_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt [N_STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            for (int i = 0; i < N_STAGES; i++)
                r_stall_cnt[i] <= '0;
        end else if (!freeze_i) begin
            for (int i = 0; i < N_STAGES; i++)
                if (stage_vld_i[i] && !stage_rdy_i[i] && (r_stall_cnt[i] != CNT_MAX))
                    r_stall_cnt[i] <= r_stall_cnt[i] + 1'b1;
        end
    end

    always_comb begin
        w_stall_rd = '0;
        for (int i = 0; i < N_STAGES; i++)
            if (sel_i[3:0] == 4'(i))
                w_stall_rd = 32'(r_stall_cnt[i]);
    end
`else
    assign w_stall_rd = '0;
`endif

    // High nibble picks the register group, low nibble the stage/channel index.
    always_comb begin
        w_rd = '0;
        case (sel_i[7:4])
            4'h0: begin
                case (sel_i[3:0])
                    4'h0:    w_rd = SIGNATURE;
                    4'h1:    w_rd = 32'(r_cyc_cnt);
                    4'h2:    w_rd = 32'({r_vld_seen, r_rdy_seen});
                    4'h3:    w_rd = 32'(r_capt_hit);
                    default: w_rd = '0;
                endcase
            end
            4'h1: for (int i = 0; i < N_STAGES; i++)
                      if (sel_i[3:0] == 4'(i)) w_rd = 32'(r_vld_cnt[i]);
            4'h2: for (int i = 0; i < N_STAGES; i++)
                      if (sel_i[3:0] == 4'(i)) w_rd = 32'(r_first_ts[i]);
            4'h3: for (int k = 0; k < N_CAPT; k++)
                      if (sel_i[3:0] == 4'(k)) w_rd = 32'(r_capt_data[k]);
            4'h4:    w_rd = w_stall_rd;
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            debug_o <= '0;
            flags_o <= '0;
        end else begin
            debug_o <= w_rd;
            flags_o <= {r_rdy_seen, r_vld_seen};
        end
    end

endmodule

// File: tb/tb_pipe_debug_monitor.sv
// Bench for pipe_debug_monitor: directed scenarios plus random traffic against a count-based reference model.
module tb_pipe_debug_monitor;

    localparam int          NS  = 4;
    localparam int          NC  = 2;
    localparam logic [31:0] SIG = 32'd13122003;
    localparam longint      MAX_FULL = 64'd4294967295;
    localparam longint      MAX_4    = 64'd15;

    logic          clk = 1'b0;
    logic          rst_n, clr_i, freeze_i, mon_en_i;
    logic [NS-1:0] stage_vld_i, stage_rdy_i;
    logic [15:0]   mon_addr_i;
    logic [31:0]   mon_data_i;
    logic [31:0]   capt_addr_i;
    logic [7:0]    sel_i;
    logic [31:0]   debug_o, debug4;
    logic [2*NS-1:0] flags_o, flags4;

    int checks = 0;
    int failures = 0;

    // Reference model: unsaturated event counts; saturation applied at readout.
    int          m_cyc;
    int          m_vcnt [NS];
    int          m_ts   [NS];
    int          m_stall[NS];
    bit          m_vs   [NS];
    bit          m_rs   [NS];
    logic [31:0] m_cd   [NC];
    bit          m_ch   [NC];
    logic [15:0] capt   [NC];

    always #5 clk = ~clk;

    pipe_debug_monitor #(.N_STAGES(NS), .N_CAPT(NC), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .freeze_i(freeze_i),
        .stage_vld_i(stage_vld_i), .stage_rdy_i(stage_rdy_i),
        .mon_en_i(mon_en_i), .mon_addr_i(mon_addr_i), .mon_data_i(mon_data_i),
        .capt_addr_i(capt_addr_i), .sel_i(sel_i), .debug_o(debug_o), .flags_o(flags_o));

    pipe_debug_monitor #(.N_STAGES(NS), .N_CAPT(NC), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .freeze_i(freeze_i),
        .stage_vld_i(stage_vld_i), .stage_rdy_i(stage_rdy_i),
        .mon_en_i(mon_en_i), .mon_addr_i(mon_addr_i), .mon_data_i(mon_data_i),
        .capt_addr_i(capt_addr_i), .sel_i(sel_i), .debug_o(debug4), .flags_o(flags4));

    function automatic logic [31:0] sat(int v, longint maxv);
        return (longint'(v) > maxv) ? 32'(maxv) : 32'(v);
    endfunction

    function logic [31:0] expect_rd(logic [7:0] s, longint maxv);
        int idx;
        logic [31:0] r;
        idx = int'(s[3:0]);
        r = '0;
        case (s[7:4])
            4'h0: begin
                if (idx == 0) r = SIG;
                else if (idx == 1) r = sat(m_cyc, maxv);
                else if (idx == 2) for (int i = 0; i < NS; i++) begin r[i] = m_rs[i]; r[NS+i] = m_vs[i]; end
                else if (idx == 3) for (int k = 0; k < NC; k++) r[k] = m_ch[k];
            end
            4'h1: if (idx < NS) r = sat(m_vcnt[idx], maxv);
            4'h2: if (idx < NS) r = sat(m_ts[idx], maxv);
            4'h3: if (idx < NC) r = m_cd[idx];
`ifdef DBG_STALL_CNT_EN
            4'h4: if (idx < NS) r = sat(m_stall[idx], maxv);
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    function logic [31:0] expect_flags();
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < NS; i++) begin f[i] = m_vs[i]; f[NS+i] = m_rs[i]; end
        return f;
    endfunction

    task automatic model_update();
        if (!rst_n || clr_i) begin
            m_cyc = 0;
            for (int i = 0; i < NS; i++) begin
                m_vcnt[i] = 0; m_ts[i] = 0; m_stall[i] = 0; m_vs[i] = 0; m_rs[i] = 0;
            end
            for (int k = 0; k < NC; k++) begin m_cd[k] = '0; m_ch[k] = 0; end
        end else if (!freeze_i) begin
            for (int i = 0; i < NS; i++) begin
                if (stage_vld_i[i]) begin
                    if (!m_vs[i]) m_ts[i] = m_cyc;
                    m_vs[i] = 1;
                    m_vcnt[i]++;
                    if (!stage_rdy_i[i]) m_stall[i]++;
                end
                if (stage_rdy_i[i]) m_rs[i] = 1;
            end
            for (int k = 0; k < NC; k++)
                if (mon_en_i && mon_addr_i == capt[k]) begin m_cd[k] = mon_data_i; m_ch[k] = 1; end
            m_cyc++;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict registered outputs from pre-edge state, advance model, compare after the edge.
    task automatic step();
        logic [31:0] e, e4, ef;
        if (!rst_n) begin e = '0; e4 = '0; ef = '0; end
        else begin e = expect_rd(sel_i, MAX_FULL); e4 = expect_rd(sel_i, MAX_4); ef = expect_flags(); end
        model_update();
        @(posedge clk);
        #1;
        chk("debug_o", debug_o, e);
        chk("debug_o_cnt4", debug4, e4);
        chk("flags_o", 32'(flags_o), ef);
        chk("flags_o_cnt4", 32'(flags4), ef);
    endtask

    task automatic idle();
        stage_vld_i = '0; stage_rdy_i = '0; mon_en_i = 1'b0; clr_i = 1'b0; freeze_i = 1'b0;
    endtask

    initial begin
        logic [31:0] c0, v0;
        capt[0] = 16'd10; capt[1] = 16'd20;
        capt_addr_i = {capt[1], capt[0]};
        rst_n = 1'b0; sel_i = 8'h00; mon_addr_i = '0; mon_data_i = '0;
        idle();
        step(); step();

        rst_n = 1'b1;
        chk("rst_debug", debug_o, 32'd0);
        chk("rst_flags", 32'(flags_o), 32'd0);
        step();
        chk("signature", debug_o, SIG);
        sel_i = 8'h01;
        for (int n = 1; n <= 3; n++) begin
            step();
            chk("cyc_climb", debug_o, 32'(n));
        end

        while (m_cyc < 10) step();
        stage_vld_i = 4'b0100;
        for (int n = 0; n < 5; n++) step();
        stage_vld_i = '0;
        sel_i = 8'h12; step();
        chk("vld_cnt2", debug_o, 32'd5);
        sel_i = 8'h22; step();
        chk("first_ts2", debug_o, 32'd10);
        step();
        chk("flag_vld2_sticky", 32'(flags_o[2]), 32'd1);

        mon_en_i = 1'b1;
        mon_addr_i = 16'd10; mon_data_i = 32'hA5; step();
        mon_addr_i = 16'd20; mon_data_i = 32'h3C; step();
        mon_addr_i = 16'd10; mon_data_i = 32'h77; step();
        mon_addr_i = 16'd30; mon_data_i = 32'hFF; step();
        mon_en_i = 1'b0;
        sel_i = 8'h30; step(); chk("capt0", debug_o, 32'h77);
        sel_i = 8'h31; step(); chk("capt1", debug_o, 32'h3C);
        sel_i = 8'h03; step(); chk("capt_hit", debug_o, 32'b11);

        freeze_i = 1'b1;
        c0 = 32'(m_cyc); v0 = 32'(m_vcnt[0]);
        for (int n = 0; n < 8; n++) begin
            stage_vld_i[0] = n[0];
            sel_i = n[0] ? 8'h10 : 8'h01;
            step();
            chk("freeze_hold", debug_o, n[0] ? v0 : c0);
        end
        stage_vld_i = '0;
        clr_i = 1'b1; step();
        clr_i = 1'b0;
        for (int g = 0; g < 4; g++)
            for (int ix = 0; ix < 4; ix++) begin
                sel_i = 8'((g << 4) | ix);
                if (sel_i == 8'h00) continue;
                step();
                chk("clr_zero", debug_o, 32'd0);
            end

        freeze_i = 1'b0;
        stage_vld_i = 4'b0010;
        for (int n = 0; n < 20; n++) step();
        stage_vld_i = '0;
        sel_i = 8'h11; step();
        chk("vld_cnt1_sat4", debug4, 32'd15);
        chk("vld_cnt1_full", debug_o, 32'd20);
        stage_vld_i = 4'b0010; clr_i = 1'b1; step();
        stage_vld_i = '0; clr_i = 1'b0; step();
        chk("clr_vs_vld_cnt", debug_o, 32'd0);
        sel_i = 8'h02; step();
        chk("clr_vs_vld_seen", 32'(debug_o[NS+1]), 32'd0);

        clr_i = 1'b1; step(); clr_i = 1'b0;
        stage_vld_i = 4'b1000; stage_rdy_i = 4'b0000;
        for (int n = 0; n < 6; n++) step();
        stage_rdy_i = 4'b1000; step();
        idle();
        sel_i = 8'h43; step();
`ifdef DBG_STALL_CNT_EN
        chk("stall_cnt3", debug_o, 32'd6);
`else
        chk("stall_cnt3", debug_o, 32'd0);
`endif

        for (int n = 0; n < 400; n++) begin
            int a;
            stage_vld_i = 4'($urandom);
            stage_rdy_i = 4'($urandom);
            mon_en_i    = 1'($urandom);
            a = $urandom_range(0, 3);
            mon_addr_i  = (a == 0) ? 16'd10 : (a == 1) ? 16'd20 : (a == 2) ? 16'd30 : 16'($urandom);
            mon_data_i  = $urandom;
            clr_i       = ($urandom_range(0, 39) == 0);
            freeze_i    = ($urandom_range(0, 7) == 0);
            rst_n       = !(n == 200);
            sel_i       = 8'(($urandom_range(0, 5) << 4) | $urandom_range(0, 5));
            step();
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
